mem_access_unit: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM register outputs and performs loads and stores over a single-outstanding req/ack data bus.
- Stalls the pipeline while an access is in flight.
- Drives the MEM/WB register inputs: write-back enable, rd, and final write-back data, with loads already lane-aligned and sign/zero-extended.

---
 rtl/mem_access_unit_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM stage: RV32I opcodes, load/store funct3 codes
// and FSM state encodings.
package mem_access_unit_pkg;

    localparam logic [6:0] RISCV_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] RISCV_OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    function automatic logic funct3_legal(input logic [6:0] opcode, input logic [2:0] funct3);
        if (opcode == RISCV_OP_LOAD)
            return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                   (funct3 == F3_LBU) || (funct3 == F3_LHU);
        if (opcode == RISCV_OP_STORE)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data replication and byte enables,
// load lane selection with sign/zero extension, and misalignment detection.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                be    = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    load_byte = rdata[7:0];
            2'd1:    load_byte = rdata[15:8];
            2'd2:    load_byte = rdata[23:16];
            default: load_byte = rdata[31:24];
        endcase
        load_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_data = {24'd0, load_byte};
            F3_LHU:  load_data = {16'd0, load_half};
            default: load_data = rdata;
        endcase
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: single-outstanding req/ack data bus access with pipeline stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        exmem2mem_wb_en_i,
    input  logic        exmem2mem_we_i,
    input  logic [31:0] exmem2mem_data_i,
    input  logic [31:0] exmem2mem_mem_addr_i,
    input  logic [6:0]  exmem2mem_opcode_i,
    input  logic [2:0]  exmem2mem_funct3_i,
    input  logic [4:0]  exmem2mem_rd_i,
    output logic        mem2memwb_wb_en_o,
    output logic [4:0]  mem2memwb_rd_o,
    output logic [31:0] mem2memwb_data_o,
    output logic        mem_stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      load_q;
    logic             abort_q;
    logic             bus_err_q;

    logic        is_load, is_store, is_mem, legal, trap, go;
    logic [31:0] lane_wdata, lane_load;
    logic [3:0]  lane_be;
    logic        lane_misaligned;

    mem_lane_align u_lane (
        .funct3     (exmem2mem_funct3_i),
        .addr_lo    (exmem2mem_mem_addr_i[1:0]),
        .store_data (exmem2mem_data_i),
        .rdata      (load_q),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

    assign is_load  = (exmem2mem_opcode_i == RISCV_OP_LOAD);
    assign is_store = (exmem2mem_opcode_i == RISCV_OP_STORE);
    assign is_mem   = is_load | is_store;
    assign legal    = funct3_legal(exmem2mem_opcode_i, exmem2mem_funct3_i);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = lane_misaligned;
`else
    assign trap = 1'b0;
`endif

    assign go = is_mem & legal & ~trap;

    // Ack wins over the watchdog when both land in the same REQ cycle.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state     <= MEM_IDLE;
            cnt       <= '0;
            load_q    <= '0;
            abort_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (go) begin
                        state   <= MEM_REQ;
                        cnt     <= '0;
                        abort_q <= 1'b0;
                    end
                end
                MEM_REQ: begin
                    if (bus_ack_i) begin
                        load_q <= bus_rdata_i;
                        state  <= MEM_DONE;
                    end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                        abort_q   <= 1'b1;
                        bus_err_q <= 1'b1;
                        state     <= MEM_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEM_DONE: state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
        end
    end

    assign bus_err_o = bus_err_q;

    always_comb begin
        mem2memwb_wb_en_o = 1'b0;
        mem2memwb_rd_o    = '0;
        mem2memwb_data_o  = '0;
        mem_stall_o       = 1'b0;
        bus_req_o         = 1'b0;
        bus_we_o          = 1'b0;
        bus_addr_o        = '0;
        bus_wdata_o       = '0;
        bus_be_o          = '0;
        misalign_o        = 1'b0;
        if (!rest) begin
            case (state)
                MEM_IDLE: begin
                    mem2memwb_rd_o = exmem2mem_rd_i;
                    if (!is_mem) begin
                        mem2memwb_wb_en_o = exmem2mem_wb_en_i;
                        mem2memwb_data_o  = exmem2mem_data_i;
                    end else if (go) begin
                        mem_stall_o = 1'b1;
                    end else begin
                        mem2memwb_data_o = exmem2mem_data_i;
                        misalign_o       = trap & legal;
                    end
                end
                MEM_REQ: begin
                    mem_stall_o    = 1'b1;
                    bus_req_o      = 1'b1;
                    bus_we_o       = is_store & exmem2mem_we_i;
                    bus_addr_o     = {exmem2mem_mem_addr_i[31:2], 2'b00};
                    bus_wdata_o    = lane_wdata;
                    bus_be_o       = lane_be;
                    mem2memwb_rd_o = exmem2mem_rd_i;
                end
                MEM_DONE: begin
                    mem2memwb_wb_en_o = exmem2mem_wb_en_i & is_load & ~abort_q;
                    mem2memwb_rd_o    = exmem2mem_rd_i;
                    mem2memwb_data_o  = lane_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit (watchdog set to 4 cycles);
// honours MEM_MISALIGN_TRAP_EN for the misaligned-word sequence.
module tb_mem_access_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam int K_PASS = 0;
    localparam int K_MEM  = 1;
    localparam int K_ILL  = 2;

    logic        clk;
    logic        rest;
    logic        wb_en_i, we_i;
    logic [31:0] data_i, addr_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        wb_en_o;
    logic [4:0]  rd_o;
    logic [31:0] data_o;
    logic        stall_o, req_o, bwe_o;
    logic [31:0] baddr_o, bwdata_o;
    logic [3:0]  be_o;
    logic [31:0] rdata_i;
    logic        ack_i;
    logic        err_o, misalign_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int          kind;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_cyc;
        logic        exp_wb;
        logic [31:0] exp_data;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
    } vec_t;

    vec_t vecs[15];

    mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk                  (clk),
        .rest                 (rest),
        .exmem2mem_wb_en_i    (wb_en_i),
        .exmem2mem_we_i       (we_i),
        .exmem2mem_data_i     (data_i),
        .exmem2mem_mem_addr_i (addr_i),
        .exmem2mem_opcode_i   (opcode_i),
        .exmem2mem_funct3_i   (funct3_i),
        .exmem2mem_rd_i       (rd_i),
        .mem2memwb_wb_en_o    (wb_en_o),
        .mem2memwb_rd_o       (rd_o),
        .mem2memwb_data_o     (data_o),
        .mem_stall_o          (stall_o),
        .bus_req_o            (req_o),
        .bus_we_o             (bwe_o),
        .bus_addr_o           (baddr_o),
        .bus_wdata_o          (bwdata_o),
        .bus_be_o             (be_o),
        .bus_rdata_i          (rdata_i),
        .bus_ack_i            (ack_i),
        .bus_err_o            (err_o),
        .misalign_o           (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Drives one EX/MEM instruction just after a rising edge.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input logic wb, input logic [4:0] rd,
                                 input logic [31:0] rdata);
        @(posedge clk);
        #1;
        opcode_i = op;
        funct3_i = f3;
        addr_i   = addr;
        data_i   = data;
        wb_en_i  = wb;
        we_i     = (op == OP_STORE);
        rd_i     = rd;
        rdata_i  = rdata;
        ack_i    = 1'b0;
    endtask

    task automatic applyNop();
        applyStimulus(OP_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic runVector(input int idx);
        vec_t v;
        int   stalls;
        v = vecs[idx];
        applyStimulus(v.opcode, v.funct3, v.addr, v.data, v.wb_en, v.rd, v.rdata);
        @(negedge clk);
        if (v.kind == K_PASS) begin
            checkOutput($sformatf("v%0d pass wb_en", idx), {31'd0, wb_en_o}, {31'd0, v.exp_wb});
            checkOutput($sformatf("v%0d pass data", idx), data_o, v.exp_data);
            checkOutput($sformatf("v%0d pass rd", idx), {27'd0, rd_o}, {27'd0, v.rd});
            checkOutput($sformatf("v%0d pass stall", idx), {31'd0, stall_o}, 32'd0);
            checkOutput($sformatf("v%0d pass req", idx), {31'd0, req_o}, 32'd0);
        end else if (v.kind == K_ILL) begin
            checkOutput($sformatf("v%0d illegal stall", idx), {31'd0, stall_o}, 32'd0);
            checkOutput($sformatf("v%0d illegal req", idx), {31'd0, req_o}, 32'd0);
            checkOutput($sformatf("v%0d illegal wb_en", idx), {31'd0, wb_en_o}, 32'd0);
        end else begin
            stalls = int'(stall_o);
            checkOutput($sformatf("v%0d idle req", idx), {31'd0, req_o}, 32'd0);
            for (int c = 1; c <= v.ack_cyc; c++) begin
                @(posedge clk);
                #1;
                ack_i = (c == v.ack_cyc);
                @(negedge clk);
                stalls += int'(stall_o);
                checkOutput($sformatf("v%0d req cyc%0d", idx, c), {31'd0, req_o}, 32'd1);
                if (c == 1) begin
                    checkOutput($sformatf("v%0d bus_addr", idx), baddr_o, v.exp_baddr);
                    checkOutput($sformatf("v%0d bus_be", idx), {28'd0, be_o}, {28'd0, v.exp_be});
                    checkOutput($sformatf("v%0d bus_wdata", idx), bwdata_o, v.exp_wdata);
                    checkOutput($sformatf("v%0d bus_we", idx), {31'd0, bwe_o}, {31'd0, v.exp_we});
                end
            end
            @(posedge clk);
            #1;
            ack_i = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("v%0d stall cycles", idx), stalls, 1 + v.ack_cyc);
            checkOutput($sformatf("v%0d done stall", idx), {31'd0, stall_o}, 32'd0);
            checkOutput($sformatf("v%0d done req", idx), {31'd0, req_o}, 32'd0);
            checkOutput($sformatf("v%0d done wb_en", idx), {31'd0, wb_en_o}, {31'd0, v.exp_wb});
            checkOutput($sformatf("v%0d done rd", idx), {27'd0, rd_o}, {27'd0, v.rd});
            if (v.exp_wb)
                checkOutput($sformatf("v%0d done data", idx), data_o, v.exp_data);
        end
    endtask

    initial begin
        int req_cnt;
        int err_cnt;

        //          kind    opcode    f3      addr          data          wb    rd     rdata         ack exp_wb exp_data      baddr         be       wdata         we
        vecs[0]  = '{K_MEM,  OP_LOAD,  3'b000, 32'h0000_1003, 32'h0,        1'b1, 5'd5,  32'h80FF_1234, 2, 1'b1, 32'hFFFF_FF80, 32'h0000_1000, 4'b1000, 32'h0,         1'b0};
        vecs[1]  = '{K_MEM,  OP_STORE, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 5'd9,  32'h0,         1, 1'b0, 32'h0,         32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1};
        vecs[2]  = '{K_MEM,  OP_LOAD,  3'b101, 32'h0000_0010, 32'h0,        1'b1, 5'd3,  32'h0000_8001, 1, 1'b1, 32'h0000_8001, 32'h0000_0010, 4'b0011, 32'h0,         1'b0};
        vecs[3]  = '{K_MEM,  OP_LOAD,  3'b001, 32'h0000_0012, 32'h0,        1'b1, 5'd4,  32'h8001_7FFF, 1, 1'b1, 32'hFFFF_8001, 32'h0000_0010, 4'b1100, 32'h0,         1'b0};
        vecs[4]  = '{K_MEM,  OP_LOAD,  3'b100, 32'h0000_0021, 32'h0,        1'b1, 5'd6,  32'h1234_A5C3, 3, 1'b1, 32'h0000_00A5, 32'h0000_0020, 4'b0010, 32'h0,         1'b0};
        vecs[5]  = '{K_MEM,  OP_LOAD,  3'b010, 32'h0000_0040, 32'h0,        1'b1, 5'd10, 32'hDEAD_BEEF, 1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 4'b1111, 32'h0,         1'b0};
        vecs[6]  = '{K_MEM,  OP_STORE, 3'b000, 32'h0000_0301, 32'h1234_56AB, 1'b0, 5'd0,  32'h0,         2, 1'b0, 32'h0,         32'h0000_0300, 4'b0010, 32'hABAB_ABAB, 1'b1};
        vecs[7]  = '{K_MEM,  OP_STORE, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 5'd0,  32'h0,         4, 1'b0, 32'h0,         32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 1'b1};
        vecs[8]  = '{K_MEM,  OP_LOAD,  3'b000, 32'h0000_1000, 32'h0,        1'b1, 5'd11, 32'h0000_007F, 1, 1'b1, 32'h0000_007F, 32'h0000_1000, 4'b0001, 32'h0,         1'b0};
        vecs[9]  = '{K_MEM,  OP_LOAD,  3'b000, 32'h0000_1002, 32'h0,        1'b0, 5'd0,  32'h00FF_0000, 1, 1'b0, 32'h0,         32'h0000_1000, 4'b0100, 32'h0,         1'b0};
        vecs[10] = '{K_PASS, OP_ALU,   3'b000, 32'h0,         32'h1111_2222, 1'b1, 5'd7,  32'h0,         0, 1'b1, 32'h1111_2222, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[11] = '{K_PASS, OP_BR,    3'b000, 32'h0,         32'h0000_0005, 1'b0, 5'd0,  32'h0,         0, 1'b0, 32'h0000_0005, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[12] = '{K_ILL,  OP_LOAD,  3'b011, 32'h0000_0100, 32'h0,        1'b1, 5'd8,  32'h0,         0, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[13] = '{K_ILL,  OP_STORE, 3'b100, 32'h0000_0104, 32'h1,        1'b0, 5'd0,  32'h0,         0, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[14] = '{K_MEM,  OP_LOAD,  3'b101, 32'h0000_0012, 32'h0,        1'b1, 5'd12, 32'h8001_7FFF, 2, 1'b1, 32'h0000_8001, 32'h0000_0010, 4'b1100, 32'h0,         1'b0};

        rest     = 1'b1;
        opcode_i = OP_ALU;
        funct3_i = 3'b000;
        addr_i   = 32'h0;
        data_i   = 32'h1234_5678;
        wb_en_i  = 1'b1;
        we_i     = 1'b0;
        rd_i     = 5'd1;
        rdata_i  = 32'h0;
        ack_i    = 1'b0;

        #2;
        checkOutput("reset wb_en", {31'd0, wb_en_o}, 32'd0);
        checkOutput("reset data", data_o, 32'd0);
        checkOutput("reset req", {31'd0, req_o}, 32'd0);
        checkOutput("reset stall", {31'd0, stall_o}, 32'd0);
        checkOutput("reset bus_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rest = 1'b0;

        for (int i = 0; i < 15; i++) runVector(i);

        // Watchdog: no ack ever; req lasts 4 cycles, err pulses as it drops.
        $display("[TB] watchdog sequence");
        applyStimulus(OP_LOAD, 3'b010, 32'h0000_0080, 32'h0, 1'b1, 5'd13, 32'h5555_5555);
        @(negedge clk);
        checkOutput("timeout idle stall", {31'd0, stall_o}, 32'd1);
        req_cnt = 0;
        err_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_cnt += int'(req_o);
            err_cnt += int'(err_o);
            if (c == 5) begin
                checkOutput("timeout err on abort", {31'd0, err_o}, 32'd1);
                checkOutput("timeout done wb_en", {31'd0, wb_en_o}, 32'd0);
                checkOutput("timeout done stall", {31'd0, stall_o}, 32'd0);
            end
        end
        checkOutput("timeout req cycles", req_cnt, 4);
        checkOutput("timeout err cycles", err_cnt, 1);
        applyNop();
        @(negedge clk);
        checkOutput("timeout err cleared", {31'd0, err_o}, 32'd0);
        checkOutput("timeout stall released", {31'd0, stall_o}, 32'd0);

        // Reset landing in the second REQ cycle, then a clean restart.
        $display("[TB] reset-mid-access sequence");
        applyStimulus(OP_LOAD, 3'b010, 32'h0000_0050, 32'h0, 1'b1, 5'd14, 32'h0BAD_F00D);
        @(posedge clk);
        @(posedge clk);
        #1;
        rest = 1'b1;
        #1;
        checkOutput("rst mid req", {31'd0, req_o}, 32'd0);
        checkOutput("rst mid stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        rest = 1'b0;
        #1;
        checkOutput("rst restart idle stall", {31'd0, stall_o}, 32'd1);
        checkOutput("rst restart idle req", {31'd0, req_o}, 32'd0);
        @(posedge clk);
        #1;
        ack_i = 1'b1;
        @(negedge clk);
        checkOutput("rst restart req", {31'd0, req_o}, 32'd1);
        checkOutput("rst restart addr", baddr_o, 32'h0000_0050);
        @(posedge clk);
        #1;
        ack_i = 1'b0;
        @(negedge clk);
        checkOutput("rst restart wb_en", {31'd0, wb_en_o}, 32'd1);
        checkOutput("rst restart data", data_o, 32'h0BAD_F00D);

        // Misaligned word load at 0x6.
        $display("[TB] misaligned word sequence");
        applyStimulus(OP_LOAD, 3'b010, 32'h0000_0006, 32'h0, 1'b1, 5'd15, 32'h1122_3344);
        @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis trap pulse", {31'd0, misalign_o}, 32'd1);
        checkOutput("mis trap stall", {31'd0, stall_o}, 32'd0);
        checkOutput("mis trap wb_en", {31'd0, wb_en_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mis trap no req", {31'd0, req_o}, 32'd0);
        applyNop();
        @(negedge clk);
        checkOutput("mis trap pulse ended", {31'd0, misalign_o}, 32'd0);
`else
        checkOutput("mis flag off", {31'd0, misalign_o}, 32'd0);
        checkOutput("mis idle stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk);
        #1;
        ack_i = 1'b1;
        @(negedge clk);
        checkOutput("mis req", {31'd0, req_o}, 32'd1);
        checkOutput("mis bus_addr", baddr_o, 32'h0000_0004);
        checkOutput("mis bus_be", {28'd0, be_o}, 32'h0000_000F);
        @(posedge clk);
        #1;
        ack_i = 1'b0;
        @(negedge clk);
        checkOutput("mis done data", data_o, 32'h1122_3344);
        applyNop();
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
